// File: rtl/a_dly_pkg.sv
// Shared types and helpers for the a_dly_line delay line.
package a_dly_pkg;

  // Settle FSM states
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } dly_state_e;

  // Requests beyond the deepest stage saturate at the deepest stage
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_sel);
    return (sel > max_sel) ? max_sel : sel;
  endfunction

  // Even-parity bit: makes the total count of ones even. Zero-extended
  // inputs keep their parity, so narrower samples can be passed in directly.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/a_dly_stage.sv
// One delay-line stage: {vld, dat[, par]} register.
// Optional parity storage is enabled by the A_DLY_LINE_PAR_EN macro.
module a_dly_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kill,
  input  logic             d_vld,
  input  logic [WIDTH-1:0] d_dat,
`ifdef A_DLY_LINE_PAR_EN
  input  logic             d_par,
  output logic             q_par,
`endif
  output logic             q_vld,
  output logic [WIDTH-1:0] q_dat
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
`ifdef A_DLY_LINE_PAR_EN
  logic             par_q, par_d;
`endif

  // Advance on en; kill drops the valid whether or not the stage advances
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
`ifdef A_DLY_LINE_PAR_EN
    par_d = par_q;
`endif
    if (en) begin
      vld_d = d_vld & ~kill;
      dat_d = d_dat;
`ifdef A_DLY_LINE_PAR_EN
      par_d = d_par;
`endif
    end else if (kill) begin
      vld_d = 1'b0;
    end
  end

  // Stage register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
`ifdef A_DLY_LINE_PAR_EN
      par_q <= 1'b0;
`endif
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
`ifdef A_DLY_LINE_PAR_EN
      par_q <= par_d;
`endif
    end
  end

  assign q_vld = vld_q;
  assign q_dat = dat_q;
`ifdef A_DLY_LINE_PAR_EN
  assign q_par = par_q;
`endif

endmodule

// File: rtl/a_dly_line.sv
// Run-time selectable multi-bit delay line with valid, stall, flush and
// a settle FSM that blanks out_vld after every delay change.
// Optional per-stage parity and out_perr port: define A_DLY_LINE_PAR_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_RUN    | delay stable, out_vld follows the selected tap
// ST_SETTLE | delay just changed, out_vld forced 0 while pipe refills
module a_dly_line
  import a_dly_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_DELAY = 8,
  localparam int SEL_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] dly_sel,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld,
  output logic             busy,
  output logic [SEL_W-1:0] cur_dly
`ifdef A_DLY_LINE_PAR_EN
  ,
  output logic             out_perr
`endif
);

  dly_state_e       state_q, state_d;
  logic [SEL_W-1:0] cur_dly_q, cur_dly_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_cl;
  logic             chg;

  logic             stg_vld [MAX_DELAY];
  logic [WIDTH-1:0] stg_dat [MAX_DELAY];
`ifdef A_DLY_LINE_PAR_EN
  logic             stg_par [MAX_DELAY];
`endif

  assign sel_cl = SEL_W'(clamp_sel(32'(dly_sel), int'(MAX_DELAY)));

  // Settle FSM next state; a new delay (re)starts SETTLE from either state
  always_comb begin
    state_d   = state_q;
    cur_dly_d = cur_dly_q;
    cnt_d     = cnt_q;
    chg       = en && (sel_cl != cur_dly_q);
    unique case (state_q)
      ST_RUN: begin
        if (chg) begin
          state_d   = ST_SETTLE;
          cur_dly_d = sel_cl;
          cnt_d     = sel_cl;
        end
      end
      ST_SETTLE: begin
        if (chg) begin
          cur_dly_d = sel_cl;
          cnt_d     = sel_cl;
        end else if (en) begin
          // Leaving on count 1 or 0 makes a zero delay still settle one cycle
          if (cnt_q <= SEL_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Settle FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cur_dly_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_dly_q <= cur_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stage chain; a delay change kills everything already in flight but
  // lets the current input into the head stage
  for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic             kill;
`ifdef A_DLY_LINE_PAR_EN
    logic             p_in;
`endif
    if (k == 0) begin : g_head
      assign v_in = in_vld;
      assign d_in = in_dat;
      assign kill = flush;
`ifdef A_DLY_LINE_PAR_EN
      assign p_in = even_par(64'(in_dat));
`endif
    end else begin : g_tail
      assign v_in = stg_vld[k-1];
      assign d_in = stg_dat[k-1];
      assign kill = flush | chg;
`ifdef A_DLY_LINE_PAR_EN
      assign p_in = stg_par[k-1];
`endif
    end

    a_dly_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .kill  (kill),
      .d_vld (v_in),
      .d_dat (d_in),
`ifdef A_DLY_LINE_PAR_EN
      .d_par (p_in),
      .q_par (stg_par[k]),
`endif
      .q_vld (stg_vld[k]),
      .q_dat (stg_dat[k])
    );
  end

  logic             tap_vld;
  logic [WIDTH-1:0] tap_dat;
`ifdef A_DLY_LINE_PAR_EN
  logic             tap_par;
  logic             tap_byp;
`endif

  // Output tap select; delay 0 bypasses the stages combinationally
  always_comb begin
    tap_vld = in_vld;
    tap_dat = in_dat;
`ifdef A_DLY_LINE_PAR_EN
    tap_par = 1'b0;
    tap_byp = 1'b1;
`endif
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (cur_dly_q == SEL_W'(k + 1)) begin
        tap_vld = stg_vld[k];
        tap_dat = stg_dat[k];
`ifdef A_DLY_LINE_PAR_EN
        tap_par = stg_par[k];
        tap_byp = 1'b0;
`endif
      end
    end
  end

  assign busy    = (state_q == ST_SETTLE);
  assign cur_dly = cur_dly_q;
  assign out_dat = tap_dat;
  assign out_vld = tap_vld & ~busy;
`ifdef A_DLY_LINE_PAR_EN
  assign out_perr = ~tap_byp & out_vld & (even_par(64'(tap_dat)) ^ tap_par);
`endif

endmodule

// File: tb/tb_a_dly_line.sv
// Self-checking bench for a_dly_line: directed table, corner sequences,
// then random traffic against a history-queue reference model.
module tb_a_dly_line;

  localparam int WIDTH = 8;
  localparam int MAXD  = 8;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst, en, flush, in_vld;
  logic [SEL_W-1:0] dly_sel;
  logic [WIDTH-1:0] in_dat;
  logic [WIDTH-1:0] out_dat;
  logic             out_vld, busy;
  logic [SEL_W-1:0] cur_dly;
`ifdef A_DLY_LINE_PAR_EN
  logic             out_perr;
`endif

  a_dly_line #(.WIDTH(WIDTH), .MAX_DELAY(MAXD)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .flush   (flush),
    .dly_sel (dly_sel),
    .in_dat  (in_dat),
    .in_vld  (in_vld),
    .out_dat (out_dat),
    .out_vld (out_vld),
    .busy    (busy),
    .cur_dly (cur_dly)
`ifdef A_DLY_LINE_PAR_EN
    ,
    .out_perr(out_perr)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: hv/hd[i] = sample accepted i+1 enabled edges ago
  logic             hv [MAXD];
  logic [WIDTH-1:0] hd [MAXD];
  int               m_cur;
  int               m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < MAXD; k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
    m_cur  = 0;
    m_busy = 0;
  endtask

  task automatic model_update();
    int  ns;
    bit  chg;
    if (rst) begin
      model_reset();
      return;
    end
    ns  = (int'(dly_sel) > MAXD) ? MAXD : int'(dly_sel);
    chg = en && (ns != m_cur);
    if (en) begin
      for (int k = MAXD - 1; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      hv[0] = in_vld;
      hd[0] = in_dat;
    end
    if (chg) begin
      for (int k = 1; k < MAXD; k++) hv[k] = 1'b0;
      m_cur  = ns;
      m_busy = (ns == 0) ? 1 : ns;
    end else if (en && m_busy > 0) begin
      m_busy--;
    end
    if (flush) begin
      for (int k = 0; k < MAXD; k++) hv[k] = 1'b0;
    end
  endtask

  task automatic model_compare();
    logic             ev;
    logic [WIDTH-1:0] ed;
    if (m_cur == 0) begin
      ev = in_vld;
      ed = in_dat;
    end else begin
      ev = hv[m_cur-1];
      ed = hd[m_cur-1];
    end
    ev = ev & (m_busy == 0);
    check("out_vld", 32'(out_vld), 32'(ev));
    check("out_dat", 32'(out_dat), 32'(ed));
    check("busy", 32'(busy), 32'(m_busy != 0));
    check("cur_dly", 32'(cur_dly), 32'(m_cur));
`ifdef A_DLY_LINE_PAR_EN
    check("out_perr", 32'(out_perr), 32'(0));
`endif
  endtask

  task automatic drive(input logic r, input logic e, input logic f, input logic [SEL_W-1:0] s,
                       input logic v, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst = r; en = e; flush = f; dly_sel = s; in_vld = v; in_dat = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  // Checked cycle
  task automatic cyc(input logic e, input logic f, input logic [SEL_W-1:0] s,
                     input logic v, input logic [WIDTH-1:0] d);
    drive(1'b0, e, f, s, v, d);
    model_compare();
    tick();
  endtask

  typedef struct {
    logic             en;
    logic             fl;
    logic [SEL_W-1:0] sel;
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic             e_vld;
    logic [WIDTH-1:0] e_dat;
    logic             e_busy;
    logic [SEL_W-1:0] e_cur;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int               first;
    logic [WIDTH-1:0] got [$];
    int               s;
    int               bcnt;
    int               vcnt;
    logic             fz_v;
    logic [WIDTH-1:0] fz_d;
    logic [WIDTH-1:0] rd;
    bit               stall;

    tbl[0]  = '{1'b1, 1'b0, 4'd0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'd2, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd2, 1'b1, 8'h22, 1'b0, 8'h5A, 1'b1, 4'd2};
    tbl[3]  = '{1'b1, 1'b0, 4'd2, 1'b1, 8'h33, 1'b0, 8'h11, 1'b1, 4'd2};
    tbl[4]  = '{1'b1, 1'b0, 4'd2, 1'b0, 8'h44, 1'b1, 8'h22, 1'b0, 4'd2};
    tbl[5]  = '{1'b0, 1'b0, 4'd2, 1'b1, 8'h55, 1'b1, 8'h33, 1'b0, 4'd2};
    tbl[6]  = '{1'b1, 1'b1, 4'd2, 1'b1, 8'h66, 1'b1, 8'h33, 1'b0, 4'd2};
    tbl[7]  = '{1'b1, 1'b0, 4'd2, 1'b1, 8'h77, 1'b0, 8'h44, 1'b0, 4'd2};
    tbl[8]  = '{1'b1, 1'b0, 4'd2, 1'b1, 8'h88, 1'b0, 8'h66, 1'b0, 4'd2};
    tbl[9]  = '{1'b1, 1'b0, 4'd0, 1'b1, 8'h99, 1'b1, 8'h77, 1'b0, 4'd2};
    tbl[10] = '{1'b1, 1'b0, 4'd0, 1'b1, 8'hA0, 1'b0, 8'hA0, 1'b1, 4'd0};
    tbl[11] = '{1'b1, 1'b0, 4'd0, 1'b1, 8'hB1, 1'b1, 8'hB1, 1'b0, 4'd0};

    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 8'hFF);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    check("rst_out_vld", 32'(out_vld), 32'(0));
    check("rst_out_dat", 32'(out_dat), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cur_dly", 32'(cur_dly), 32'(0));
    tick();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, tbl[i].en, tbl[i].fl, tbl[i].sel, tbl[i].vld, tbl[i].dat);
      check($sformatf("tbl%0d_vld", i), 32'(out_vld), 32'(tbl[i].e_vld));
      check($sformatf("tbl%0d_dat", i), 32'(out_dat), 32'(tbl[i].e_dat));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_cur", i), 32'(cur_dly), 32'(tbl[i].e_cur));
      tick();
    end

    // Steady delay 3: stream 0x01..0x10
    for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, 4'd3, 1'b0, 8'h00);
    first = -1;
    got.delete();
    for (int c = 0; c < 24; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd3, c < 16, 8'(c + 1));
      model_compare();
      if (out_vld) begin
        if (first < 0) first = c;
        got.push_back(out_dat);
      end
      tick();
    end
    check("steady_latency", 32'(first), 32'(3));
    check("steady_count", 32'(got.size()), 32'(16));
    for (int i = 0; i < 16 && i < got.size(); i++)
      check($sformatf("steady_seq%0d", i), 32'(got[i]), 32'(i + 1));

    // Stall: delay 4, en=0 for 5 cycles mid-stream
    for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0, 4'd4, 1'b0, 8'h00);
    got.delete();
    s = 0;
    fz_v = 1'b0;
    fz_d = '0;
    for (int c = 0; c < 30; c++) begin
      stall = (c >= 6 && c < 11);
      drive(1'b0, !stall, 1'b0, 4'd4, s < 12, 8'(8'h40 + s));
      model_compare();
      if (c == 6) begin
        fz_v = out_vld;
        fz_d = out_dat;
      end else if (stall) begin
        check("stall_vld_frozen", 32'(out_vld), 32'(fz_v));
        check("stall_dat_frozen", 32'(out_dat), 32'(fz_d));
      end
      if (out_vld && !stall) got.push_back(out_dat);
      if (!stall && s < 12) s++;
      tick();
    end
    check("stall_count", 32'(got.size()), 32'(12));
    for (int i = 0; i < 12 && i < got.size(); i++)
      check($sformatf("stall_seq%0d", i), 32'(got[i]), 32'(8'h40 + i));

    // Delay change 3 -> 6 while streaming
    for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0, 4'd3, 1'b1, 8'(8'h70 + c));
    bcnt = 0;
    vcnt = 0;
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 8'(8'h80 + c));
      model_compare();
      if (busy) bcnt++;
      if (busy && out_vld) vcnt++;
      if (c == 10) begin
        check("chg_out_dat", 32'(out_dat), 32'(8'h84));
        check("chg_out_vld", 32'(out_vld), 32'(1));
        check("chg_cur_dly", 32'(cur_dly), 32'(6));
      end
      tick();
    end
    check("chg_busy_cycles", 32'(bcnt), 32'(6));
    check("chg_vld_while_busy", 32'(vcnt), 32'(0));

    // Zero delay bypass
    for (int c = 0; c < 2; c++) cyc(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      rd = 8'($urandom);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, rd);
      model_compare();
      check("bypass_dat", 32'(out_dat), 32'(rd));
      check("bypass_vld", 32'(out_vld), 32'(1));
      tick();
    end

    // Clamp: 15 -> 8
    for (int c = 0; c < 10; c++) cyc(1'b1, 1'b0, 4'd15, 1'b0, 8'h00);
    check("clamp_cur_dly", 32'(cur_dly), 32'(8));
    first = -1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd15, c == 0, (c == 0) ? 8'hC3 : 8'h00);
      model_compare();
      if (out_vld && first < 0) begin
        first = c;
        check("clamp_dat", 32'(out_dat), 32'(8'hC3));
      end
      tick();
    end
    check("clamp_latency", 32'(first), 32'(8));

    // Flush with samples in flight at delay 4
    for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0, 4'd4, 1'b0, 8'h00);
    vcnt = 0;
    for (int c = 0; c < 13; c++) begin
      drive(1'b0, 1'b1, c == 4, 4'd4, c < 4, 8'(8'hD0 + c));
      model_compare();
      if (c >= 5 && out_vld) vcnt++;
      tick();
    end
    check("flush_none_emerge", 32'(vcnt), 32'(0));

    // Reset wins over flush and a delay change
    drive(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 8'hEE);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    check("prio_out_vld", 32'(out_vld), 32'(0));
    check("prio_out_dat", 32'(out_dat), 32'(0));
    check("prio_busy", 32'(busy), 32'(0));
    check("prio_cur_dly", 32'(cur_dly), 32'(0));
    tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [SEL_W-1:0] rs;
      rs = ($urandom_range(0, 19) == 0) ? SEL_W'($urandom_range(0, 15)) : dly_sel;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 19) == 0, rs, 1'($urandom), 8'($urandom));
      model_compare();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/a_dly_line.md
Name: a_dly_line

Overview:
- Parametrised multi-bit delay line with a valid qualifier. It replaces fixed single-bit n-clock delay flops in datapath alignment.
- Delay is selectable at run time, from 0 to MAX_DELAY cycles.
- A clock enable provides stall support. A flush clears the pipe.
- A settle state machine blanks the output valid after a delay change, so stale or duplicated samples never reach the output.

Parameters:
- WIDTH, 8, data bits per sample.
- MAX_DELAY, 8, deepest selectable delay in cycles. Must be at least 1.
- SEL_W, clog2(MAX_DELAY+1), width of dly_sel. Derived; not overridden by instantiators.

Ports:
- clk  in  1  rising-edge clock, the block's only clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  advance enable. 0 = hold all state.
- flush  in  1  clears all stage valids. Data contents are don't-care.
- dly_sel  in  SEL_W  requested delay in cycles.
- in_dat  in  WIDTH  input sample.
- in_vld  in  1  input sample valid.
- out_dat  out  WIDTH  delayed sample.
- out_vld  out  1  delayed valid.
- busy  out  1  high while the settle FSM is not in RUN.
- cur_dly  out  SEL_W  delay currently applied.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valids = 0, cur_dly = 0, FSM = RUN, settle counter = 0.
  - out_vld = 0, busy = 0.
  - out_dat reset value = 0 (stage data regs reset to 0).
- Storage: MAX_DELAY stages, each holding {vld, dat}. With en=1, stage[0] <= {in_vld, in_dat} and stage[k] <= stage[k-1].
- Output tap:
  - cur_dly = 0: out_dat = in_dat and out_vld = in_vld & ~busy. Combinational, zero latency.
  - Otherwise: out = stage[cur_dly-1]. Valid is masked by ~busy.
- Latency: a sample accepted at edge N (en=1) appears at out after cur_dly enabled edges. Stalled cycles (en=0) do not count.
- en=0: stages, settle counter and FSM all hold. Outputs stay stable (except the cur_dly=0 bypass, which follows its inputs).
- dly_sel clamp: any value above MAX_DELAY is treated as MAX_DELAY.
- FSM states: RUN and SETTLE.
  - RUN → SETTLE: when en=1 and the clamped dly_sel differs from cur_dly. On that edge:
    - cur_dly <= new value.
    - All stage valids are cleared (the edge's input still enters stage[0]).
    - Settle counter <= new value.
  - SETTLE: out_vld is forced 0. The counter decrements on each en=1 edge. The transition to RUN happens on the edge where the counter is 1 or 0, so busy lasts exactly new_dly enabled cycles.
  - New delay of 0: SETTLE lasts 1 cycle.
- dly_sel changing again during SETTLE: restart SETTLE with the newest value, reload the counter and clear the valids again.
- flush=1 (en is don't-care): clear all stage valids next edge. FSM and cur_dly are unchanged. A flush in the same cycle as in_vld=1 drops that input.
- Simultaneous rst and flush/dly change: rst wins.
- Simultaneous flush and dly change: both apply. The FSM enters SETTLE.

Optional Feature:
- Macro: A_DLY_LINE_PAR_EN.
- Defined:
  - Each stage stores an extra even-parity bit of in_dat.
  - New output port out_perr (1 bit) = recomputed parity of out_dat XOR stored parity, qualified by out_vld.
  - In bypass (delay 0), out_perr = 0.
- Undefined: no parity storage and no out_perr port. Behaviour is otherwise identical.

Decomposition:
- Shared package a_dly_pkg:
  - FSM state typedef: RUN, SETTLE.
  - Clamp function (sel, max).
  - Parity function.
- Sub-module a_dly_stage: one {vld, dat[, par]} register with en, flush and synchronous reset. Instantiated MAX_DELAY times by a generate loop.

Test Plan:
- Reset then steady delay: WIDTH=8, dly_sel=3. Drive in_dat 0x01..0x10 with in_vld=1 → first out_vld 3 cycles after the first input. out_dat sequence 0x01..0x10 in order, no gaps.
- Stall: dly_sel=4 with a stream, en=0 for 5 cycles mid-stream → out_dat/out_vld frozen during the stall. Total latency is 4 enabled edges. No sample is lost.
- Delay change: switch dly_sel 3→6 while streaming → busy=1 and out_vld=0 for exactly 6 cycles. After that, output equals the input from 6 cycles earlier. cur_dly=6.
- Zero and clamp:
  - dly_sel=0 → out_dat equals in_dat in the same cycle.
  - dly_sel=15 with MAX_DELAY=8 → cur_dly=8 and latency 8.
- Flush and priority:
  - flush pulse with 4 valid samples in flight → none emerge.
  - rst together with flush and a dly change → all outputs 0, cur_dly=0, busy=0.
- Parity (A_DLY_LINE_PAR_EN): force a bit flip in stage 2 → out_perr=1 exactly when that sample emerges, 0 otherwise.
